// File: rtl/rvc_cs_pkg.sv
// Shared types and encodings for the RVC CS-format execution unit.
// RV64 encodings are enabled by the RVC_CS_RV64_EN macro.
package rvc_cs_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM
  } state_e;

  typedef enum logic [3:0] {
    D_AND,
    D_OR,
    D_XOR,
    D_SUB,
    D_SUBW,
    D_ADDW,
    D_SW,
    D_SD,
    D_ILL
  } dec_op_e;

  localparam logic [1:0] OP_C0 = 2'b00;
  localparam logic [1:0] OP_C1 = 2'b01;

  localparam logic [2:0] F3_SW = 3'b110;
  localparam logic [2:0] F3_SD = 3'b111;

  localparam logic [7:0] F8_AND  = 8'b1000_1111;
  localparam logic [7:0] F8_OR   = 8'b1000_1110;
  localparam logic [7:0] F8_XOR  = 8'b1000_1101;
  localparam logic [7:0] F8_SUB  = 8'b1000_1100;
  localparam logic [7:0] F8_SUBW = 8'b1001_1100;
  localparam logic [7:0] F8_ADDW = 8'b1001_1101;

  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

  function automatic logic is_alu(dec_op_e op);
    return op inside {D_AND, D_OR, D_XOR,
                      D_SUB, D_SUBW, D_ADDW};
  endfunction

  function automatic logic is_store(dec_op_e op);
    return op inside {D_SW, D_SD};
  endfunction

endpackage

// File: rtl/rvc_cs_exec_unit_if.sv
// Instruction, write-back and store bus of the CS execution unit.
// Signal names follow the unit's port list (i = into unit).
interface rvc_cs_exec_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8
);
  logic              iVALID;
  logic              oREADY;
  logic [15:0]       iIR;
  logic [4:0]        oRS1;
  logic [4:0]        oRS2;
  logic [XLEN-1:0]   iRS1;
  logic [XLEN-1:0]   iRS2;
  logic [4:0]        oRD;
  logic              oWB_VALID;
  logic [XLEN-1:0]   oWB_DATA;
  logic              oMEM_REQ;
  logic              iMEM_ACK;
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic [XLEN-1:0]   oMEM_DATA;
  logic [XLEN/8-1:0] oMEM_BE;
  logic              oDONE;
  logic              oFAULT;
  logic [1:0]        oFAULT_CODE;

  modport slave (
    input  iVALID, iIR, iRS1, iRS2, iMEM_ACK,
    output oREADY, oRS1, oRS2, oRD,
    output oWB_VALID, oWB_DATA,
    output oMEM_REQ, oMEM_ADDR, oMEM_DATA, oMEM_BE,
    output oDONE, oFAULT, oFAULT_CODE
  );

  modport master (
    output iVALID, iIR, iRS1, iRS2, iMEM_ACK,
    input  oREADY, oRS1, oRS2, oRD,
    input  oWB_VALID, oWB_DATA,
    input  oMEM_REQ, oMEM_ADDR, oMEM_DATA, oMEM_BE,
    input  oDONE, oFAULT, oFAULT_CODE
  );

endinterface

// File: rtl/rvc_cs_decode.sv
// Combinational CS-format decode: op class, register indices, immediate.
// c.subw/c.addw/c.sd decode only when RVC_CS_RV64_EN is defined.
module rvc_cs_decode
  import rvc_cs_pkg::*;
(
  input  logic [15:0] ir,
  output dec_op_e     op,
  output logic [4:0]  rs1_idx,
  output logic [4:0]  rs2_idx,
  output logic [7:0]  imm
);

  logic [1:0] opc;
  logic [2:0] f3;
  logic [7:0] f8;

  assign opc = ir[1:0];
  assign f3  = ir[15:13];
  assign f8  = {ir[15:10], ir[6:5]};

  assign rs1_idx = {2'b01, ir[9:7]};
  assign rs2_idx = {2'b01, ir[4:2]};

  always_comb begin
    op  = D_ILL;
    imm = '0;
    unique case (1'b1)
      (opc == OP_C1 && f8 == F8_AND): op = D_AND;
      (opc == OP_C1 && f8 == F8_OR):  op = D_OR;
      (opc == OP_C1 && f8 == F8_XOR): op = D_XOR;
      (opc == OP_C1 && f8 == F8_SUB): op = D_SUB;
      (opc == OP_C0 && f3 == F3_SW): begin
        op  = D_SW;
        imm = {1'b0, ir[5], ir[12:10],
               ir[6], 2'b00};
      end
`ifdef RVC_CS_RV64_EN
      (opc == OP_C1 && f8 == F8_SUBW): op = D_SUBW;
      (opc == OP_C1 && f8 == F8_ADDW): op = D_ADDW;
      (opc == OP_C0 && f3 == F3_SD): begin
        op  = D_SD;
        imm = {ir[6:5], ir[12:10], 3'b000};
      end
`endif
      default: op = D_ILL;
    endcase
  end

endmodule

// File: rtl/rvc_cs_exec_unit.sv
// Handshaked executor for RVC CS-format ALU ops and stores.
// Define RVC_CS_RV64_EN (with XLEN=64) for c.subw, c.addw and c.sd.
module rvc_cs_exec_unit
  import rvc_cs_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 8,
  parameter int ADDR_SHIFT = 2,
  parameter int TIMEOUT    = 16
) (
  input logic iCLK,
  input logic iRST_N,
  rvc_cs_exec_unit_if.slave bus
);

  localparam int BW = XLEN / 8;
  localparam int CW = $clog2(TIMEOUT + 2);

  dec_op_e    op;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [7:0] imm;

  rvc_cs_decode u_dec (
    .ir      (bus.iIR),
    .op      (op),
    .rs1_idx (rs1_idx),
    .rs2_idx (rs2_idx),
    .imm     (imm)
  );

  assign bus.oRS1 = rs1_idx;
  assign bus.oRS2 = rs2_idx;

  state_e state;
  state_e state_nx;

  logic accept;
  logic alu_op;
  logic st_op;
  logic tmo;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] alu;
  logic [XLEN-1:0] eff;
  logic [XLEN-1:0] st_data;
  logic [BW-1:0]   st_be;
  logic            mis;
  logic            unused_ok;

  logic              pend;
  logic [CW-1:0]     cnt;
  logic              wb_valid;
  logic [XLEN-1:0]   wb_data;
  logic [4:0]        rd;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_data;
  logic [BW-1:0]     mem_be;
  logic              done;
  logic              fault;
  logic [1:0]        fault_code;

  assign accept = bus.iVALID && (state == S_IDLE);
  assign alu_op = is_alu(op);
  assign st_op  = is_store(op);

  assign a   = bus.iRS1;
  assign b   = bus.iRS2;
  assign eff = a + XLEN'(imm);

  assign unused_ok = ^eff;

  // the watchdog fires on the TIMEOUT-th cycle spent in MEM
  assign tmo = (TIMEOUT != 0) &&
               (cnt == CW'(TIMEOUT - 1));

`ifdef RVC_CS_RV64_EN
  logic [31:0] w;
`endif

  always_comb begin
    alu = '0;
`ifdef RVC_CS_RV64_EN
    w   = '0;
`endif
    unique case (op)
      D_AND: alu = a & b;
      D_OR:  alu = a | b;
      D_XOR: alu = a ^ b;
      D_SUB: alu = a - b;
`ifdef RVC_CS_RV64_EN
      D_SUBW: begin
        w   = a[31:0] - b[31:0];
        alu = {{(XLEN-32){w[31]}}, w};
      end
      D_ADDW: begin
        w   = a[31:0] + b[31:0];
        alu = {{(XLEN-32){w[31]}}, w};
      end
`endif
      default: alu = '0;
    endcase
  end

  always_comb begin
    mis     = 1'b0;
    st_data = b;
    st_be   = '1;
    unique case (op)
      D_SW: begin
        mis = |eff[1:0];
`ifdef RVC_CS_RV64_EN
        // word store lands in one half of the doubleword lane
        st_data = {2{b[31:0]}};
        st_be   = eff[2] ? BW'(8'hF0)
                         : BW'(8'h0F);
`endif
      end
`ifdef RVC_CS_RV64_EN
      D_SD: mis = |eff[2:0];
`endif
      default: mis = 1'b0;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_EXEC;
      S_EXEC: state_nx = pend ? S_MEM : S_IDLE;
      S_MEM: begin
        if (bus.iMEM_ACK || tmo)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pend       <= 1'b0;
      cnt        <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      rd         <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_be     <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= '0;
    end else begin
      wb_valid <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            pend <= 1'b0;
            unique case (1'b1)
              alu_op: begin
                wb_valid <= 1'b1;
                done     <= 1'b1;
                wb_data  <= alu;
                rd       <= rs1_idx;
              end
              (st_op && mis): begin
                fault      <= 1'b1;
                fault_code <= FLT_MISALIGN;
              end
              (st_op && !mis): begin
                pend     <= 1'b1;
                mem_addr <= eff[ADDR_SHIFT+ADDR_W-1:
                               ADDR_SHIFT];
                mem_data <= st_data;
                mem_be   <= st_be;
              end
              default: begin
                fault      <= 1'b1;
                fault_code <= FLT_ILLEGAL;
              end
            endcase
          end
        end
        S_EXEC: begin
          if (pend) begin
            mem_req <= 1'b1;
            cnt     <= '0;
          end
        end
        S_MEM: begin
          pend <= 1'b0;
          if (bus.iMEM_ACK) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
          end else if (tmo) begin
            mem_req    <= 1'b0;
            fault      <= 1'b1;
            fault_code <= FLT_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: pend <= 1'b0;
      endcase
    end
  end

  assign bus.oREADY      = (state == S_IDLE);
  assign bus.oWB_VALID   = wb_valid;
  assign bus.oWB_DATA    = wb_data;
  assign bus.oRD         = rd;
  assign bus.oMEM_REQ    = mem_req;
  assign bus.oMEM_ADDR   = mem_addr;
  assign bus.oMEM_DATA   = mem_data;
  assign bus.oMEM_BE     = mem_be;
  assign bus.oDONE       = done;
  assign bus.oFAULT      = fault;
  assign bus.oFAULT_CODE = fault_code;

endmodule

// File: tb/tb_rvc_cs_exec_unit.sv
// Directed plus random bench for rvc_cs_exec_unit (XLEN=32, TIMEOUT=4)
// against an instruction-level reference model.
module tb_rvc_cs_exec_unit;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] last_code = 2'b00;

  always #5 clk = ~clk;

  rvc_cs_exec_unit_if #(.XLEN(32), .ADDR_W(8)) bus ();

  rvc_cs_exec_unit #(
    .XLEN(32), .ADDR_W(8),
    .ADDR_SHIFT(2), .TIMEOUT(TMO)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // sel: 3 and, 2 or, 1 xor, 0 sub
  function automatic logic [15:0] enc_alu(
      input logic [1:0] sel,
      input logic [2:0] rdp,
      input logic [2:0] rsp);
    return {6'b100011, rdp, sel, rsp, 2'b01};
  endfunction

  function automatic logic [15:0] enc_sw(
      input logic [6:0] im,
      input logic [2:0] rs1p,
      input logic [2:0] rs2p);
    return {3'b110, im[5:3], rs1p,
            im[2], im[6], rs2p, 2'b00};
  endfunction

  // kind: 0 write-back, 1 store, 2 misaligned, 3 illegal
  function automatic void model(
      input  logic [15:0] ir,
      input  logic [31:0] a,
      input  logic [31:0] b,
      output int          kind,
      output logic [31:0] val,
      output logic [7:0]  ad);
    int imm;
    logic [31:0] e;
    kind = 3;
    val  = '0;
    ad   = '0;
    if (ir[1:0] == 2'd1 &&
        ir[15:10] == 6'b100011) begin
      kind = 0;
      case (ir[6:5])
        2'd0: val = a - b;
        2'd1: val = a ^ b;
        2'd2: val = a | b;
        default: val = a & b;
      endcase
    end else if (ir[1:0] == 2'd0 &&
                 ir[15:13] == 3'b110) begin
      imm = ir[5] * 64 + ir[12:10] * 8 + ir[6] * 4;
      e   = a + imm;
      if (e % 4 != 0) kind = 2;
      else begin
        kind = 1;
        ad   = 8'((e / 4) % 256);
      end
    end
  endfunction

  task automatic run(input logic [15:0] ir,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int ack_n);
    int kind;
    logic [31:0] val;
    logic [7:0] ad;
    model(ir, a, b, kind, val, ad);
    chk("ready_idle", bus.oREADY, 1);
    bus.iIR    = ir;
    bus.iRS1   = a;
    bus.iRS2   = b;
    bus.iVALID = 1'b1;
    #1;
    chk("rs1_idx", bus.oRS1, 8 + ir[9:7]);
    chk("rs2_idx", bus.oRS2, 8 + ir[4:2]);
    step();
    bus.iVALID = 1'b0;
    bus.iRS1   = $urandom;
    bus.iRS2   = $urandom;
    chk("ready_busy", bus.oREADY, 0);
    case (kind)
      0: begin
        chk("wb_valid", bus.oWB_VALID, 1);
        chk("wb_rd", bus.oRD, 8 + ir[9:7]);
        chk("wb_data", bus.oWB_DATA, val);
        chk("alu_done", bus.oDONE, 1);
        chk("alu_nofault", bus.oFAULT, 0);
        chk("code_held", bus.oFAULT_CODE, last_code);
        step();
        chk("wb_pulse", bus.oWB_VALID, 0);
      end
      2, 3: begin
        last_code = (kind == 2) ? 2'b01 : 2'b11;
        chk("fault", bus.oFAULT, 1);
        chk("fault_code", bus.oFAULT_CODE, last_code);
        chk("flt_noreq", bus.oMEM_REQ, 0);
        chk("flt_nowb", bus.oWB_VALID, 0);
        step();
        chk("fault_pulse", bus.oFAULT, 0);
      end
      default: begin
        chk("exec_noreq", bus.oMEM_REQ, 0);
        step();
        for (int n = 1; n <= TMO; n++) begin
          chk("req", bus.oMEM_REQ, 1);
          chk("mem_addr", bus.oMEM_ADDR, ad);
          chk("mem_data", bus.oMEM_DATA, b);
          chk("mem_be", bus.oMEM_BE, 4'hF);
          if (n == ack_n) bus.iMEM_ACK = 1'b1;
          step();
          bus.iMEM_ACK = 1'b0;
          if (n == ack_n) begin
            chk("st_done", bus.oDONE, 1);
            chk("st_nofault", bus.oFAULT, 0);
            chk("req_drop", bus.oMEM_REQ, 0);
            break;
          end
          if (n == TMO) begin
            last_code = 2'b10;
            chk("tmo_fault", bus.oFAULT, 1);
            chk("tmo_code", bus.oFAULT_CODE, 2'b10);
            chk("tmo_nodone", bus.oDONE, 0);
            chk("tmo_drop", bus.oMEM_REQ, 0);
          end
        end
      end
    endcase
    chk("ready_back", bus.oREADY, 1);
  endtask

  initial begin
    int r;
    bus.iVALID   = 1'b0;
    bus.iIR      = '0;
    bus.iRS1     = '0;
    bus.iRS2     = '0;
    bus.iMEM_ACK = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.oREADY, 1);
    chk("rst_wbv", bus.oWB_VALID, 0);
    chk("rst_wbd", bus.oWB_DATA, 0);
    chk("rst_rd", bus.oRD, 0);
    chk("rst_req", bus.oMEM_REQ, 0);
    chk("rst_addr", bus.oMEM_ADDR, 0);
    chk("rst_data", bus.oMEM_DATA, 0);
    chk("rst_be", bus.oMEM_BE, 0);
    chk("rst_done", bus.oDONE, 0);
    chk("rst_fault", bus.oFAULT, 0);
    chk("rst_code", bus.oFAULT_CODE, 0);
    rst_n = 1'b1;
    step();

    run(enc_alu(2'd3, 3'd1, 3'd2),
        32'hF0F0_00FF, 32'h0FF0_FF0F, 0);
    run(enc_alu(2'd0, 3'd0, 3'd0), 32'd0, 32'd1, 0);
    run(enc_alu(2'd2, 3'd5, 3'd6),
        32'h1200_0034, 32'h0056_7800, 0);
    run(enc_alu(2'd1, 3'd7, 3'd3),
        32'hFFFF_0000, 32'h0F0F_0F0F, 0);
    run(enc_sw(7'd8, 3'd1, 3'd2),
        32'h40, 32'hDEAD_BEEF, 3);
    run(enc_sw(7'd0, 3'd1, 3'd2),
        32'h41, 32'h1234_5678, 0);
    run(enc_alu(2'd3, 3'd1, 3'd1),
        32'hA5A5_A5A5, 32'hFFFF_0000, 0);
    run(enc_sw(7'd124, 3'd3, 3'd4),
        32'hFFFF_FF80, 32'hCAFE_F00D, 0);
    run(enc_sw(7'd4, 3'd3, 3'd4),
        32'h200, 32'h0BAD_F00D, TMO);
    run(16'hFFFF, 32'd1, 32'd2, 0);

    // reset abandons a store in flight
    bus.iIR    = enc_sw(7'd0, 3'd0, 3'd1);
    bus.iRS1   = 32'h100;
    bus.iRS2   = 32'h5555_AAAA;
    bus.iVALID = 1'b1;
    step();
    bus.iVALID = 1'b0;
    step();
    chk("pre_rst_req", bus.oMEM_REQ, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", bus.oMEM_REQ, 0);
    chk("arst_ready", bus.oREADY, 1);
    chk("arst_addr", bus.oMEM_ADDR, 0);
    chk("arst_code", bus.oFAULT_CODE, 0);
    last_code = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    run(16'h0003, 32'd7, 32'd9, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 5);
      if (r < 4)
        run(enc_alu(2'(r), 3'($urandom),
                    3'($urandom)),
            $urandom, $urandom, 0);
      else if (r == 4)
        run(enc_sw(7'($urandom), 3'($urandom),
                   3'($urandom)),
            $urandom, $urandom,
            $urandom_range(0, TMO + 2));
      else
        run(16'($urandom), $urandom, $urandom,
            $urandom_range(1, TMO));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
